// File: rtl/pixel_fb.sv
// pixel_fb: pixel frame buffer with a CPU port, an independent scanout port and a clear engine.
// Double buffering with a frame_start-timed swap is built only when PIXEL_FB_DOUBLE_BUFFER_EN is defined.
module pixel_fb #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int BPP    = 1,
    parameter int ADDR_W = 19
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [BPP-1:0]    cpu_wdata,
    input  logic              cpu_we,
    output logic [BPP-1:0]    cpu_rdata,
    input  logic [ADDR_W-1:0] scan_addr,
    output logic [BPP-1:0]    scan_data,
    input  logic              frame_start,
    input  logic              swap_req,
    output logic              swap_pending,
    output logic              front_sel,
    input  logic              clr_req,
    input  logic [BPP-1:0]    clr_color,
    output logic              clr_busy
);

    localparam int NPIX  = H_RES * V_RES;
    localparam int IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam logic [ADDR_W:0]  PIX_LIMIT = (ADDR_W + 1)'(NPIX);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NPIX - 1);

    typedef enum logic {
        CLR_IDLE,
        CLR_FILL
    } clr_state_t;

    clr_state_t       state;
    clr_state_t       state_next;
    logic [IDX_W-1:0] fill_cnt;
    logic [IDX_W-1:0] fill_cnt_next;
    logic [BPP-1:0]   fill_color;
    logic [BPP-1:0]   fill_color_next;
    logic             fill_we;

    logic             cpu_in_range;
    logic             scan_in_range;
    logic [IDX_W-1:0] cpu_idx;
    logic [IDX_W-1:0] scan_idx;

    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [BPP-1:0]   wr_data;

    // Addresses past the last pixel never write and always read back as zero.
    assign cpu_in_range  = {1'b0, cpu_addr} < PIX_LIMIT;
    assign scan_in_range = {1'b0, scan_addr} < PIX_LIMIT;
    assign cpu_idx       = cpu_addr[IDX_W-1:0];
    assign scan_idx      = scan_addr[IDX_W-1:0];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= CLR_IDLE;
            fill_cnt   <= '0;
            fill_color <= '0;
        end else begin
            state      <= state_next;
            fill_cnt   <= fill_cnt_next;
            fill_color <= fill_color_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        state_next      = state;
        fill_cnt_next   = fill_cnt;
        fill_color_next = fill_color;
        fill_we         = 1'b0;
        case (state)
            CLR_IDLE: begin
                if (clr_req) begin
                    state_next      = CLR_FILL;
                    fill_cnt_next   = '0;
                    fill_color_next = clr_color;
                end
            end
            CLR_FILL: begin
                fill_we = 1'b1;
                if (fill_cnt == LAST_IDX) begin
                    state_next = CLR_IDLE;
                end else begin
                    fill_cnt_next = fill_cnt + IDX_W'(1);
                end
            end
            default: state_next = CLR_IDLE;
        endcase
    end

    assign clr_busy = (state == CLR_FILL);

    // The clear engine owns the write port while busy; CPU writes in that window are dropped.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = cpu_idx;
        wr_data = cpu_wdata;
        if (resetn) begin
            if (fill_we) begin
                wr_en   = 1'b1;
                wr_idx  = fill_cnt;
                wr_data = fill_color;
            end else if (cpu_we && cpu_in_range) begin
                wr_en = 1'b1;
            end
        end
    end

`ifdef PIXEL_FB_DOUBLE_BUFFER_EN
    logic [BPP-1:0] bank0 [NPIX];
    logic [BPP-1:0] bank1 [NPIX];
    logic           front_q;
    logic           pending_q;

    // A pending swap waits for a frame_start that arrives while no clear is running.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            front_q   <= 1'b0;
            pending_q <= 1'b0;
        end else if (frame_start && pending_q && !clr_busy) begin
            front_q   <= ~front_q;
            pending_q <= 1'b0;
        end else if (swap_req) begin
            pending_q <= 1'b1;
        end
    end

    assign front_sel    = front_q;
    assign swap_pending = pending_q;

    // NOTE: the pixel arrays have no reset branch; their contents survive reset and map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (front_q) begin
                bank0[wr_idx] <= wr_data;
            end else begin
                bank1[wr_idx] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cpu_rdata <= '0;
            scan_data <= '0;
        end else begin
            cpu_rdata <= cpu_in_range ? (front_q ? bank0[cpu_idx] : bank1[cpu_idx]) : '0;
            scan_data <= scan_in_range ? (front_q ? bank1[scan_idx] : bank0[scan_idx]) : '0;
        end
    end
`else
    logic [BPP-1:0] bank [NPIX];
    logic           unused_swap_inputs;

    assign unused_swap_inputs = swap_req ^ frame_start;
    assign front_sel          = 1'b0;
    assign swap_pending       = 1'b0;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            bank[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cpu_rdata <= '0;
            scan_data <= '0;
        end else begin
            cpu_rdata <= cpu_in_range ? bank[cpu_idx] : '0;
            scan_data <= scan_in_range ? bank[scan_idx] : '0;
        end
    end
`endif

endmodule

// File: tb/tb_pixel_fb.sv
// tb_pixel_fb: directed and randomized checks of pixel_fb against a behavioural frame buffer model.
`timescale 1ns/1ps
module tb_pixel_fb;

    localparam int H_RES = 8;
    localparam int V_RES = 4;
    localparam int BPP   = 4;
    // One bit wider than the pixel range needs, so addresses >= 32 are reachable.
    localparam int ADDR_W = 6;
    localparam int NPIX   = H_RES * V_RES;
    localparam int IW     = $clog2(NPIX);
`ifdef PIXEL_FB_DOUBLE_BUFFER_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              resetn;
    logic [ADDR_W-1:0] cpu_addr;
    logic [BPP-1:0]    cpu_wdata;
    logic              cpu_we;
    logic [BPP-1:0]    cpu_rdata;
    logic [ADDR_W-1:0] scan_addr;
    logic [BPP-1:0]    scan_data;
    logic              frame_start;
    logic              swap_req;
    logic              swap_pending;
    logic              front_sel;
    logic              clr_req;
    logic [BPP-1:0]    clr_color;
    logic              clr_busy;

    int checks = 0;
    int errors = 0;

    pixel_fb #(
        .H_RES (H_RES),
        .V_RES (V_RES),
        .BPP   (BPP),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_we      (cpu_we),
        .cpu_rdata   (cpu_rdata),
        .scan_addr   (scan_addr),
        .scan_data   (scan_data),
        .frame_start (frame_start),
        .swap_req    (swap_req),
        .swap_pending(swap_pending),
        .front_sel   (front_sel),
        .clr_req     (clr_req),
        .clr_color   (clr_color),
        .clr_busy    (clr_busy)
    );

    always #5 clk = ~clk;

    // Reference model: two pixel arrays, a front index, a pending flag and a remaining-fill count.
    logic [BPP-1:0] m_bank [2][NPIX];
    bit             m_front;
    bit             m_pend;
    int             m_fill_left;
    logic [BPP-1:0] m_color;
    logic [BPP-1:0] m_cpu_rd;
    logic [BPP-1:0] m_scan_rd;
    bit             m_backb;
    bit             m_frontb;
    bit             m_was_busy;
    logic [IW-1:0]  m_idx;

    always @(posedge clk) begin
        if (!resetn) begin
            m_front     = 1'b0;
            m_pend      = 1'b0;
            m_fill_left = 0;
            m_cpu_rd    = '0;
            m_scan_rd   = '0;
        end else begin
            m_frontb   = DB ? m_front : 1'b0;
            m_backb    = DB ? !m_front : 1'b0;
            m_was_busy = (m_fill_left > 0);
            m_idx      = cpu_addr[IW-1:0];
            m_cpu_rd   = (int'(cpu_addr) < NPIX) ? m_bank[m_backb][m_idx] : '0;
            m_idx      = scan_addr[IW-1:0];
            m_scan_rd  = (int'(scan_addr) < NPIX) ? m_bank[m_frontb][m_idx] : '0;
            if (m_was_busy) begin
                m_idx = IW'(NPIX - m_fill_left);
                m_bank[m_backb][m_idx] = m_color;
                m_fill_left = m_fill_left - 1;
            end else begin
                if (cpu_we && int'(cpu_addr) < NPIX) begin
                    m_idx = cpu_addr[IW-1:0];
                    m_bank[m_backb][m_idx] = cpu_wdata;
                end
                if (clr_req) begin
                    m_fill_left = NPIX;
                    m_color     = clr_color;
                end
            end
            if (DB) begin
                if (frame_start && m_pend && !m_was_busy) begin
                    m_front = !m_front;
                    m_pend  = 1'b0;
                end else if (swap_req) begin
                    m_pend = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        cpu_we      = 1'b0;
        clr_req     = 1'b0;
        swap_req    = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic wait_clear_done(input string tag);
        int n = 0;
        while (clr_busy === 1'b1 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (clr_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_clear_timeout: clr_busy=%b after %0d cycles, required 0", tag, clr_busy, n);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        drive_idle();
        cpu_addr = 6'd3; scan_addr = 6'd3;
        tick(); tick();
        checks++; if (cpu_rdata !== 4'h0) begin errors++; $display("FAIL reset_cpu_rdata: got %h required 0", cpu_rdata); end
        checks++; if (scan_data !== 4'h0) begin errors++; $display("FAIL reset_scan_data: got %h required 0", scan_data); end
        checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL reset_clr_busy: got %b required 0", clr_busy); end
        checks++; if (swap_pending !== 1'b0) begin errors++; $display("FAIL reset_swap_pending: got %b required 0", swap_pending); end
        checks++; if (front_sel !== 1'b0) begin errors++; $display("FAIL reset_front_sel: got %b required 0", front_sel); end
        resetn = 1'b1;
        tick();
    endtask

    // Fill both banks with zero so later reads have a defined history.
    task automatic init_banks();
        for (int pass = 0; pass < 2; pass++) begin
            clr_req = 1'b1; clr_color = '0; tick(); clr_req = 1'b0;
            wait_clear_done("init");
            swap_req = 1'b1; tick(); swap_req = 1'b0;
            frame_start = 1'b1; tick(); frame_start = 1'b0;
        end
    endtask

    task automatic test_write_read();
        cpu_addr = 6'd5; cpu_wdata = 4'hA; cpu_we = 1'b1; scan_addr = 6'd5;
        tick();
        cpu_we = 1'b0;
        checks++; if (cpu_rdata !== 4'h0) begin errors++; $display("FAIL wr_same_cycle_read: got %h required 0", cpu_rdata); end
        tick();
        checks++; if (cpu_rdata !== 4'hA) begin errors++; $display("FAIL wr_read_back: got %h required a", cpu_rdata); end
        checks++; if (scan_data !== (DB ? 4'h0 : 4'hA)) begin errors++; $display("FAIL wr_front_untouched: got %h required %h", scan_data, DB ? 4'h0 : 4'hA); end
        checks++; if (scan_data !== m_scan_rd) begin errors++; $display("FAIL wr_scan_model: got %h required %h", scan_data, m_scan_rd); end
    endtask

    task automatic test_swap();
        bit f0 = m_front;
        swap_req = 1'b1; tick(); swap_req = 1'b0;
        checks++; if (swap_pending !== DB) begin errors++; $display("FAIL swap_pending_set: got %b required %b", swap_pending, DB); end
        tick(); tick();
        checks++; if (swap_pending !== DB || front_sel !== f0) begin errors++; $display("FAIL swap_waiting: pending=%b front=%b required %b %b", swap_pending, front_sel, DB, f0); end
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        checks++; if (swap_pending !== 1'b0) begin errors++; $display("FAIL swap_pending_clear: got %b required 0", swap_pending); end
        checks++; if (front_sel !== (f0 ^ DB)) begin errors++; $display("FAIL swap_front_sel: got %b required %b", front_sel, f0 ^ DB); end
        scan_addr = 6'd5; tick();
        checks++; if (scan_data !== 4'hA) begin errors++; $display("FAIL swap_scan_shows_write: got %h required a", scan_data); end
    endtask

    task automatic test_swap_coincide();
        bit f0 = m_front;
        swap_req = 1'b1; frame_start = 1'b1; tick(); drive_idle();
        checks++; if (front_sel !== f0) begin errors++; $display("FAIL coincide_no_swap: got %b required %b", front_sel, f0); end
        checks++; if (swap_pending !== DB) begin errors++; $display("FAIL coincide_pending: got %b required %b", swap_pending, DB); end
        tick();
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        checks++; if (front_sel !== (f0 ^ DB) || swap_pending !== 1'b0) begin errors++; $display("FAIL coincide_next_frame: front=%b pending=%b required %b 0", front_sel, swap_pending, f0 ^ DB); end
    endtask

    task automatic test_clear();
        int busy_n = 0;
        clr_req = 1'b1; clr_color = 4'h3; tick(); clr_req = 1'b0;
        while (clr_busy === 1'b1 && busy_n < 100) begin
            busy_n++;
            cpu_we = (busy_n == 4); cpu_addr = 6'd2; cpu_wdata = 4'hF;
            clr_req = (busy_n == 6); clr_color = 4'h9;
            tick();
        end
        drive_idle();
        checks++; if (busy_n != NPIX) begin errors++; $display("FAIL clear_busy_length: got %0d cycles required %0d", busy_n, NPIX); end
        for (int i = 0; i < NPIX; i++) begin
            cpu_addr = ADDR_W'(i);
            tick();
            checks++; if (cpu_rdata !== 4'h3) begin errors++; $display("FAIL clear_pixel_%0d: got %h required 3", i, cpu_rdata); end
        end
    endtask

    task automatic test_clear_defers_swap();
        bit f0 = m_front;
        swap_req = 1'b1; tick(); swap_req = 1'b0;
        clr_req = 1'b1; clr_color = 4'($urandom_range(1, 15)); tick(); clr_req = 1'b0;
        repeat (5) tick();
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        checks++; if (front_sel !== f0 || swap_pending !== DB) begin errors++; $display("FAIL defer_during_clear: front=%b pending=%b required %b %b", front_sel, swap_pending, f0, DB); end
        wait_clear_done("defer");
        checks++; if (front_sel !== f0) begin errors++; $display("FAIL defer_after_clear: front=%b required %b", front_sel, f0); end
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        checks++; if (front_sel !== (f0 ^ DB) || swap_pending !== 1'b0) begin errors++; $display("FAIL defer_swap: front=%b pending=%b required %b 0", front_sel, swap_pending, f0 ^ DB); end
    endtask

    task automatic test_reset_mid_clear();
        swap_req = 1'b1; tick(); swap_req = 1'b0;
        clr_req = 1'b1; clr_color = 4'h6; tick(); clr_req = 1'b0;
        repeat (9) tick();
        resetn = 1'b0; tick(); resetn = 1'b1;
        checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_clr_busy: got %b required 0", clr_busy); end
        checks++; if (front_sel !== 1'b0 || swap_pending !== 1'b0) begin errors++; $display("FAIL rst_mid_swap_state: front=%b pending=%b required 0 0", front_sel, swap_pending); end
        checks++; if (cpu_rdata !== 4'h0 || scan_data !== 4'h0) begin errors++; $display("FAIL rst_mid_read_regs: cpu=%h scan=%h required 0 0", cpu_rdata, scan_data); end
        cpu_addr = 6'd32; cpu_wdata = 4'hF; cpu_we = 1'b1; tick(); cpu_we = 1'b0;
        tick();
        checks++; if (cpu_rdata !== 4'h0) begin errors++; $display("FAIL out_of_range_read: got %h required 0", cpu_rdata); end
        for (int i = 0; i < NPIX; i++) begin
            cpu_addr = ADDR_W'(i); scan_addr = ADDR_W'(i);
            tick();
            checks++; if (cpu_rdata !== m_cpu_rd || scan_data !== m_scan_rd) begin errors++; $display("FAIL rst_contents_%0d: cpu=%h scan=%h required %h %h", i, cpu_rdata, scan_data, m_cpu_rd, m_scan_rd); end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            cpu_addr    = ADDR_W'($urandom_range(0, NPIX + 7));
            cpu_wdata   = BPP'($urandom);
            cpu_we      = 1'($urandom_range(0, 1));
            scan_addr   = ADDR_W'($urandom_range(0, NPIX + 7));
            clr_req     = ($urandom_range(0, 59) == 0);
            clr_color   = BPP'($urandom);
            swap_req    = ($urandom_range(0, 7) == 0);
            frame_start = ($urandom_range(0, 9) == 0);
            tick();
            checks++;
            if (cpu_rdata !== m_cpu_rd || scan_data !== m_scan_rd || clr_busy !== (m_fill_left > 0) ||
                swap_pending !== m_pend || front_sel !== m_front) begin
                errors++;
                $display("FAIL random_cycle_%0d: cpu=%h scan=%h busy=%b pend=%b front=%b required %h %h %b %b %b",
                         c, cpu_rdata, scan_data, clr_busy, swap_pending, front_sel,
                         m_cpu_rd, m_scan_rd, (m_fill_left > 0), m_pend, m_front);
            end
        end
        drive_idle();
    endtask

    initial begin
        resetn = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; scan_addr = '0; clr_color = '0;
        drive_idle();
        test_reset();
        init_banks();
        test_write_read();
        test_swap();
        test_swap_coincide();
        test_clear();
        test_clear_defers_swap();
        test_reset_mid_clear();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
